// File: rtl/alu32_exec.sv
// alu32_exec: execute-stage datapath slice.
//   - Address adder: add_sum = add_a + add_b (mod 2^32).
//   - ALU control decode: {aluop1, aluop0} and funct select the 4-bit gout code.
//   - ALU: result and zout are computed combinationally from a, b and gout.
//   - Status flags: status_n, status_v and status_z are registered from the current
//     operation on every rising clk. They are cleared by synchronous active-low rst_n.
// Ports:
//   clk, rst_n                   clock and synchronous active-low reset
//   add_a, add_b -> add_sum      32-bit address adder
//   a, b                         32-bit ALU operands
//   aluop1, aluop0, funct[5:0]   operation select
//   gout[3:0]                    decoded ALU operation code
//   result[31:0], zout           ALU result and its combinational zero flag
//   status_n/v/z                 registered negative, overflow and zero flags
module alu32_exec (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] add_a,
  input  logic [31:0] add_b,
  output logic [31:0] add_sum,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        aluop1,
  input  logic        aluop0,
  input  logic [5:0]  funct,
  output logic [3:0]  gout,
  output logic [31:0] result,
  output logic        zout,
  output logic        status_n,
  output logic        status_v,
  output logic        status_z
);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_NOR = 4'b1100
  } alu_op_e;

  alu_op_e     op;
  logic [31:0] sum;
  logic [31:0] diff;
  logic        ovf_add;
  logic        ovf_sub;
  logic        less;
  logic        ovf;

  assign add_sum = add_a + add_b;

  always_comb begin
    op = OP_ADD;
    case ({aluop1, aluop0})
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b11: op = OP_NOR;
      2'b10: begin
        case (funct)
          6'b100000: op = OP_ADD;
          6'b100010: op = OP_SUB;
          6'b100100: op = OP_AND;
          6'b100101: op = OP_OR;
          6'b100110: op = OP_XOR;
          6'b100111: op = OP_NOR;
          6'b101010: op = OP_SLT;
          default:   op = OP_ADD;
        endcase
      end
      default: op = OP_ADD;
    endcase
  end

  assign gout = op;

  assign sum     = a + b;
  assign diff    = a - b;
  assign ovf_add = (a[31] == b[31]) && (sum[31]  != a[31]);
  assign ovf_sub = (a[31] != b[31]) && (diff[31] != a[31]);
  // The sign of the difference is inverted when the subtraction overflows,
  // so the signed comparison still holds across overflow.
  assign less    = diff[31] ^ ovf_sub;

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (gout)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_ADD: begin
        result = sum;
        ovf    = ovf_add;
      end
      OP_XOR: result = a ^ b;
      OP_SUB: begin
        result = diff;
        ovf    = ovf_sub;
      end
      OP_SLT: result = {31'b0, less};
      OP_NOR: result = ~(a | b);
      default: begin
        result = '0;
        ovf    = 1'b0;
      end
    endcase
  end

  assign zout = (result == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_n <= 1'b0;
      status_v <= 1'b0;
      status_z <= 1'b0;
    end else begin
      status_n <= result[31];
      status_v <= ovf;
      status_z <= zout;
    end
  end

endmodule

// File: tb/tb_alu32_exec.sv
// Directed testbench for alu32_exec. The expected values are hand-computed constants.
module tb_alu32_exec;

  logic        clk;
  logic        rst_n;
  logic [31:0] add_a, add_b, add_sum;
  logic [31:0] a, b, result;
  logic        aluop1, aluop0;
  logic [5:0]  funct;
  logic [3:0]  gout;
  logic        zout, status_n, status_v, status_z;

  int unsigned total = 0;
  int unsigned bad   = 0;

  alu32_exec dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_sum  (add_sum),
    .a        (a),
    .b        (b),
    .aluop1   (aluop1),
    .aluop0   (aluop0),
    .funct    (funct),
    .gout     (gout),
    .result   (result),
    .zout     (zout),
    .status_n (status_n),
    .status_v (status_v),
    .status_z (status_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [1:0] aluop, input logic [5:0] fn,
                       input logic [31:0] va, input logic [31:0] vb);
    {aluop1, aluop0} = aluop;
    funct = fn;
    a = va;
    b = vb;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic n, input logic v, input logic z);
    check({tag, "_n"}, {31'b0, status_n}, {31'b0, n});
    check({tag, "_v"}, {31'b0, status_v}, {31'b0, v});
    check({tag, "_z"}, {31'b0, status_z}, {31'b0, z});
  endtask

  initial begin
    rst_n = 1'b0;
    add_a = '0;
    add_b = '0;
    apply(2'b00, 6'b0, 32'h0, 32'h0);
    tick();
    tick();
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    add_a = 32'h0000001C; add_b = 32'h4; #1;
    check("add_sum1", add_sum, 32'h00000020);
    add_a = 32'hFFFFFFFC; add_b = 32'h4; #1;
    check("add_sum_wrap", add_sum, 32'h0);

    apply(2'b10, 6'b100000, 32'h7FFFFFFF, 32'h1);
    check("add_gout", {28'b0, gout}, 32'h2);
    check("add_res", result, 32'h80000000);
    check("add_z", {31'b0, zout}, 32'h0);
    tick();
    check_flags("add_ovf", 1'b1, 1'b1, 1'b0);

    apply(2'b01, 6'b0, 32'h5, 32'h5);
    check("sub_gout", {28'b0, gout}, 32'h6);
    check("sub_res", result, 32'h0);
    check("sub_z", {31'b0, zout}, 32'h1);
    tick();
    check_flags("sub_zero", 1'b0, 1'b0, 1'b1);

    apply(2'b10, 6'b100010, 32'h80000000, 32'h1);
    check("sub_ovf_res", result, 32'h7FFFFFFF);
    tick();
    check_flags("sub_ovf", 1'b0, 1'b1, 1'b0);

    apply(2'b10, 6'b101010, 32'h80000000, 32'h1);
    check("slt_gout", {28'b0, gout}, 32'h7);
    check("slt_neg_lt", result, 32'h1);
    apply(2'b10, 6'b101010, 32'h1, 32'h80000000);
    check("slt_pos_ge", result, 32'h0);
    apply(2'b10, 6'b101010, 32'h7FFFFFFF, 32'hFFFFFFFF);
    check("slt_ovf", result, 32'h0);
    tick();
    check_flags("slt_flags", 1'b0, 1'b0, 1'b1);

    apply(2'b11, 6'b0, 32'h0F0F0000, 32'h0000FFFF);
    check("nori_gout", {28'b0, gout}, 32'hC);
    check("nori_res", result, 32'hF0F00000);
    tick();
    check_flags("nori_flags", 1'b1, 1'b0, 1'b0);

    apply(2'b10, 6'b100110, 32'hFF00FF00, 32'h0FF00FF0);
    check("xor_gout", {28'b0, gout}, 32'h3);
    check("xor_res", result, 32'hF0F0F0F0);
    apply(2'b10, 6'b100100, 32'hF0F0F0F0, 32'h0FF00FF0);
    check("and_gout", {28'b0, gout}, 32'h0);
    check("and_res", result, 32'h00F000F0);
    apply(2'b10, 6'b100101, 32'h0F0F0000, 32'h0000FFFF);
    check("or_gout", {28'b0, gout}, 32'h1);
    check("or_res", result, 32'h0F0FFFFF);
    apply(2'b10, 6'b100111, 32'h0F0F0000, 32'h0000FFFF);
    check("nor_gout", {28'b0, gout}, 32'hC);
    check("nor_res", result, 32'hF0F00000);
    apply(2'b10, 6'b111111, 32'h00000003, 32'h00000004);
    check("unlisted_gout", {28'b0, gout}, 32'h2);
    check("unlisted_res", result, 32'h7);

    // Set the flags, then apply reset while a negative result is presented.
    apply(2'b10, 6'b100000, 32'h7FFFFFFF, 32'h1);
    tick();
    check_flags("pre_rst", 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    check_flags("mid_rst", 1'b0, 1'b0, 1'b0);
    check("rst_comb_res", result, 32'h80000000);
    check("rst_comb_sum", add_sum, 32'h0);
    rst_n = 1'b1;
    tick();
    check_flags("post_rst", 1'b1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu32_exec.md
ALU32_EXEC -- requirements
Module: alu32_exec

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, named clk and rst_n.
REQ-002 clk  input  1  rising edge samples all state (status flags only).
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 add_a  input  32  address-adder operand A (e.g. PC).
REQ-005 add_b  input  32  address-adder operand B (e.g. constant 4 or shifted offset).
REQ-006 add_sum  output  32  address-adder result.
REQ-007 a  input  32  ALU operand A (register read data 1).
REQ-008 b  input  32  ALU operand B (register data 2 or extended immediate).
REQ-009 aluop1, aluop0  input  1 each  ALU operation class from main control.
REQ-010 funct  input  6  instruction bits [5:0].
REQ-011 gout  output  4  decoded ALU operation code.
REQ-012 result  output  32  ALU result.
REQ-013 zout  output  1  combinational zero flag of result.
REQ-014 status_n, status_v, status_z  output  1 each  registered negative, overflow, zero flags.

Function
REQ-015 add_sum SHALL equal (add_a + add_b) mod 2^32, combinational, no carry-out.
REQ-016 gout decode SHALL be: {aluop1,aluop0}=00 -> 0010 (add); 01 -> 0110 (sub); 11 -> 1100 (nor, immediate form).
REQ-017 With {aluop1,aluop0}=10, gout SHALL follow funct: 100000 -> 0010 add; 100010 -> 0110 sub; 100100 -> 0000 and; 100101 -> 0001 or; 100110 -> 0011 xor; 100111 -> 1100 nor; 101010 -> 0111 slt.
REQ-018 Any unlisted funct with aluop 10 SHALL yield gout 0010 (add).
REQ-019 gout decode SHALL be purely combinational.
REQ-020 result SHALL be combinational from a, b, gout: 0000 a&b; 0001 a|b; 0010 a+b; 0011 a^b; 0110 a-b; 0111 32'h1 if signed(a)<signed(b) else 0; 1100 ~(a|b).
REQ-021 Any other gout value SHALL give result 32'h0.
REQ-022 Add/sub SHALL wrap mod 2^32.
REQ-023 slt SHALL be correct across overflow: less = diff[31] XOR ovf_sub, where diff = a-b.
REQ-024 zout SHALL be 1 exactly when result == 0, combinational.
REQ-025 Internal overflow ovf: add -> a[31]==b[31] and result[31]!=a[31]; sub -> a[31]!=b[31] and result[31]!=a[31]; all other ops -> 0.
REQ-026 On each rising clk with rst_n=1: status_n <= result[31], status_z <= zout, status_v <= ovf, from the operation currently presented.
REQ-027 Flags SHALL be updated every cycle regardless of operation; there is no enable.
REQ-028 Flags SHALL change only at the rising clk edge; combinational outputs SHALL never depend on flags.

Reset
REQ-029 On a rising clk with rst_n=0, status_n, status_v, status_z SHALL all become 0; reset dominates any simultaneous flag update.
REQ-030 Combinational outputs (add_sum, gout, result, zout) SHALL remain functional during reset.
REQ-031 Asserting reset mid-operation SHALL only clear the flags at the next edge; no other state exists.

Verification
REQ-032 add_a=32'h0000001C, add_b=32'h4 -> add_sum=32'h00000020; add_a=32'hFFFFFFFC, add_b=4 -> add_sum=0.
REQ-033 aluop=10, funct=100000, a=32'h7FFFFFFF, b=1 -> gout=0010, result=32'h80000000, zout=0; after edge status_n=1, status_v=1, status_z=0.
REQ-034 aluop=01, a=5, b=5 -> gout=0110, result=0, zout=1; after edge status_z=1, status_n=0, status_v=0.
REQ-035 aluop=10, funct=101010, a=32'h80000000, b=1 -> result=1; with a=1, b=32'h80000000 -> result=0.
REQ-036 aluop=11, a=32'h0F0F0000, b=32'h0000FFFF -> gout=1100, result=32'hF0F00000; funct=100110 with aluop=10, a=32'hFF00FF00, b=32'h0FF00FF0 -> result=32'hF0F0F0F0.
REQ-037 Flags set (status_n=1) then rst_n=0 for one edge with a negative result presented -> all flags 0; rst_n=1 next edge -> status_n=1 again.
